// File: rtl/sdram_cmd_queue_if.sv
// Controller-style user port: request (addr/rw/data_in/in_valid) one way, busy and read return the other.
// master drives requests and receives busy/read data; slave accepts requests and returns busy/read data.
interface sdram_cmd_queue_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic [DATA_W-1:0] data_in;
  logic              in_valid;
  logic              busy;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;

  modport master (
    output addr, rw, data_in, in_valid,
    input  busy, data_out, out_valid
  );

  modport slave (
    input  addr, rw, data_in, in_valid,
    output busy, data_out, out_valid
  );
endinterface

// File: rtl/sdram_cmd_queue.sv
// Command FIFO between a request source and the SDRAM controller; limits outstanding reads to MAX_RD.
// Latency: push-to-issue >= 1 cycle, read return 1 cycle. busy = queue full; define SDRAM_CMD_QUEUE_STATS_EN
// to add stall_cnt/hwm/stats_clr.
module sdram_cmd_queue #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 3,
  parameter int MAX_RD     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sdram_cmd_queue_if.slave         src,
  sdram_cmd_queue_if.master        mem,
  output logic                     overflow,
  output logic                     underflow
`ifdef SDRAM_CMD_QUEUE_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [15:0]              stall_cnt,
  output logic [DEPTH_LOG2:0]      hwm
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int RD_W  = $clog2(MAX_RD + 1);

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, THROTTLE} issue_state_t;

  cmd_t                  fifo_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_nxt;
  logic [RD_W-1:0]       rd_out, rd_out_nxt;
  cmd_t                  head;
  issue_state_t          issue_state;
  logic                  empty, full, push, pop, rd_issue, ret_ok;

  assign empty = (count == '0);
  assign full  = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign head  = fifo_mem[rd_ptr];

  // Issue control is a pure decode of registered state; no extra state register is needed.
  always_comb begin
    issue_state = ISSUE;
    if (empty)
      issue_state = IDLE;
    else if (!head.rw && rd_out == RD_W'(MAX_RD))
      issue_state = THROTTLE;
  end

  assign push     = src.in_valid && !full;
  assign pop      = (issue_state == ISSUE) && !mem.busy;
  assign rd_issue = pop && !head.rw;
  assign ret_ok   = mem.out_valid && (rd_out != '0);

  assign src.busy     = full;
  assign mem.in_valid = pop;
  assign mem.addr     = empty ? '0 : head.addr;
  assign mem.rw       = empty ? 1'b0 : head.rw;
  assign mem.data_in  = empty ? '0 : head.data;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // A return with nothing outstanding is dropped, so it must not cancel a same-cycle read issue.
  always_comb begin
    rd_out_nxt = rd_out;
    if (rd_issue && !ret_ok)
      rd_out_nxt = rd_out + 1'b1;
    else if (!rd_issue && ret_ok)
      rd_out_nxt = rd_out - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= '{rw: src.rw, addr: src.addr, data: src.data_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rd_out        <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      src.out_valid <= 1'b0;
      src.data_out  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      rd_out <= rd_out_nxt;
      if (src.in_valid && full)
        overflow <= 1'b1;
      if (mem.out_valid && rd_out == '0)
        underflow <= 1'b1;
      src.out_valid <= ret_ok;
      if (ret_ok)
        src.data_out <= mem.data_out;
    end
  end

`ifdef SDRAM_CMD_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      hwm       <= '0;
    end else if (stats_clr) begin
      stall_cnt <= '0;
      hwm       <= '0;
    end else begin
      if (!empty && !pop && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 1'b1;
      if (count_nxt > hwm)
        hwm <= count_nxt;
    end
  end
`endif

endmodule

// File: doc/sdram_cmd_queue.md
Name: sdram_cmd_queue

Overview:
- Command buffer between a request source (memory tester, DMA, CPU bridge) and the SDRAM controller.
- Decouples the source from the controller's `busy`. Requests are queued in a small FIFO and issued to the controller whenever it is ready.
- Limits in-flight reads and registers returning read data to the source.
- Source-side ports are pin-compatible with the controller's user interface, so the block drops in between them.

Parameters:
- ADDR_W, 23, address width.
- DATA_W, 32, data width.
- DEPTH_LOG2, 3, log2 of FIFO entries (default 8 entries).
- MAX_RD, 4, maximum outstanding reads issued but not yet returned (1..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- addr  in  ADDR_W  source request address.
- rw  in  1  1 = write, 0 = read.
- data_in  in  DATA_W  source write data.
- in_valid  in  1  source request strobe.
- busy  out  1  queue full; requests are not accepted.
- data_out  out  DATA_W  read data to source (registered).
- out_valid  out  1  read data valid, one-cycle pulse.
- mem_addr  out  ADDR_W  controller address (FIFO head).
- mem_rw  out  1  controller rw (FIFO head).
- mem_data_in  out  DATA_W  controller write data (FIFO head).
- mem_in_valid  out  1  controller request strobe.
- mem_busy  in  1  controller busy.
- mem_data_out  in  DATA_W  controller read data.
- mem_out_valid  in  1  controller read data valid.
- overflow  out  1  sticky: request presented while busy.
- underflow  out  1  sticky: read data returned with zero reads outstanding.

Behaviour:
- **Reset** (rst_n low, asynchronous):
  - FIFO pointers, entry count and outstanding-read counter go to 0.
  - busy=0, out_valid=0, data_out=0, mem_in_valid=0, overflow=0, underflow=0.
  - Reset mid-operation discards all queued and in-flight commands.
- **Storage:** FIFO of {rw, addr, data_in}. Entry count is DEPTH_LOG2+1 bits; pointers wrap modulo 2^DEPTH_LOG2.
- **busy:** busy = (count == 2^DEPTH_LOG2). It is derived from the registered count only, so there is no combinational path from in_valid or mem_busy.
- **Push:** in_valid && !busy writes the entry at the clock edge.
  - in_valid && busy drops the request and sets overflow. This holds even if a pop occurs in the same cycle.
- **Issue:** mem_in_valid = !empty && !mem_busy && !(head is read && rd_out == MAX_RD).
  - mem_addr, mem_rw and mem_data_in come combinationally from the FIFO head. They are 0 when the queue is empty.
  - The FIFO pops on every cycle that mem_in_valid=1.
  - Issue latency: a request pushed at edge N can be issued in cycle N+1 at the earliest.
- **Simultaneous push and pop:** count is unchanged. An empty FIFO never pops a same-cycle push; that entry issues next cycle.
- **Head-of-line blocking:** a read stalled by the MAX_RD limit also blocks any writes queued behind it. Ordering is strictly FIFO.
- **Outstanding reads:** rd_out increments when a read issues and decrements on mem_out_valid. If both happen in the same cycle, rd_out is unchanged.
  - mem_out_valid with rd_out==0: the data is dropped, rd_out stays 0, and underflow is set.
- **Read return:** data_out and out_valid are registered from mem_data_out and mem_out_valid, giving exactly 1 cycle of latency.
  - data_out holds its last value when out_valid=0.
- **Clearing flags:** overflow and underflow clear only on reset.
- **State machine:** none beyond the FIFO and counters. Issue control is IDLE (empty), ISSUE (head issuable), THROTTLE (head is a read and rd_out==MAX_RD), decoded from the registered state each cycle.

Optional Feature:
- Macro: SDRAM_CMD_QUEUE_STATS_EN.
- When defined, the block adds these ports:
  - stall_cnt (out, 16): saturating count of cycles with a non-empty queue and mem_in_valid=0.
  - hwm (out, DEPTH_LOG2+1): maximum count ever reached.
  - stats_clr (in, 1): synchronous clear of both outputs.
  - Both outputs reset to 0 on rst_n.
- When undefined, these ports and their logic are absent, and the remaining behaviour is identical.

Test Plan:
1. **Single write:** mem_busy=0; push write addr=0x000010, data=0xDEADBEEF, then in_valid=0 → mem_in_valid=1 exactly one cycle later with matching addr/data and mem_rw=1; busy stays 0.
2. **Fill to full:** mem_busy=1; push 9 writes → busy=1 after the 8th; the 9th sets overflow=1. Release mem_busy → the 8 stored entries issue in order on 8 consecutive cycles, and busy drops after the first issue.
3. **Read throttle:** MAX_RD=4, mem_busy=0; queue 6 reads with the controller never returning data → exactly 4 mem_in_valid pulses. Return one mem_out_valid with 0x12345678 → 5th read issues next cycle; out_valid=1 with data_out=0x12345678 one cycle after the return.
4. **Simultaneous push/pop at count 3:** count stays 3, no data corruption; the pushed entry is issued 4th.
5. **Spurious read data:** mem_out_valid=1 with rd_out=0 → out_valid stays 0, underflow=1.
6. **Reset mid-burst:** 5 entries queued and 2 reads outstanding; pulse rst_n low asynchronously mid-cycle → mem_in_valid=0 and busy=0 immediately; nothing issues after release until a new push.
